lsu_ctrl: RTL

Load/store sequencing controller between the CPU datapath and the data memory bus. Accepts one load or store request at a time and drives a byte-enabled memory request/acknowledge handshake. Performs byte/halfword lane selection with sign or zero extension on loads, and replicates lanes for stores. Returns a single-cycle response, and holds `busy` high so the pipeline stalls while an access is in flight.

---
 rtl/lsu_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencing controller between CPU datapath and data memory bus
//
// Accepts one load/store at a time and runs a single byte-enabled request/ack
// bus access. Loads are lane-selected and sign/zero extended. Stores have their
// lanes replicated. Completion is a one-cycle resp_valid strobe.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses. They then complete with resp_err and no bus access. When it is
// undefined, halfword accesses ignore addr[0] and word accesses ignore addr[1:0].
//
// Parameters:
//   MEM_TIMEOUT  max cycles mem_req stays high without mem_ack (1..255)
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    CPU request handshake
//   req_op                 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
//   req_addr, req_wdata    byte address, store data
//   resp_valid             one-cycle completion strobe (loads and stores)
//   resp_rdata, resp_err   extended load data, misalign/timeout error
//   busy                   pipeline stall request
//   mem_req/mem_ack        bus request/completion handshake
//   mem_we, mem_be         write enable, byte enables
//   mem_addr, mem_wdata    word address, lane-replicated store data
//   mem_rdata              read data, valid in the mem_ack cycle
module lsu_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  // Last REQ cycle index before the access is declared timed out.
  localparam logic [7:0] TMAX = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;

  logic [1:0]  off;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign busy      = (state == IDLE) ? req_valid : 1'b1;

  assign off      = req_addr[1:0];
  assign is_store = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: misaligned = off[0];
      OP_LW, OP_SW:         misaligned = (off != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane placement; loads always enable the whole word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_op)
      OP_SB: begin
        be_next    = 4'b0001 << off;
        wdata_next = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        be_next    = off[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  // Little-endian lane select and extension of the returning read data.
  always_comb begin
    sel_byte = 8'h00;
    case (off_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    case (op_q)
      OP_LW:   load_data = mem_rdata;
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0, sel_half};
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h0, sel_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
      cnt        <= 8'h00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            off_q     <= off;
            cnt       <= 8'h00;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_we    <= is_store;
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack in the final timeout cycle takes priority over the error.
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end else if (cnt == TMAX) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + 8'h01;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_req    <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
